// File: rtl/sub_serial.sv
// Bit-serial subtractor: latches a and b on a start request, then produces a - b
// LSB-first, one bit per clock, into a shift register with a final borrow flag.
//
// state | meaning
// IDLE  | waiting for en; result and borrow hold
// SUB   | one difference bit per cycle, WIDTH cycles
// DONE  | one-cycle done pulse; result valid
module sub_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             borrow;
  logic [CW-1:0]    count;
  logic             diff, borrow_nxt, last_bit;

  assign diff       = a_reg[0] ^ b_reg[0] ^ borrow;
  assign borrow_nxt = (~a_reg[0] & b_reg[0]) | (~a_reg[0] & borrow) | (b_reg[0] & borrow);
  assign last_bit   = (count == CW'(WIDTH - 1));
  assign borrow_out = borrow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (en) state_nxt = SUB;
      end
      SUB: begin
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // The difference enters at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      out    <= '0;
      borrow <= 1'b0;
      count  <= '0;
    end else if (state == IDLE && en) begin
      a_reg  <= a;
      b_reg  <= b;
      out    <= '0;
      borrow <= 1'b0;
      count  <= '0;
    end else if (state == SUB) begin
      out    <= {diff, out[WIDTH-1:1]};
      borrow <= borrow_nxt;
      a_reg  <= a_reg >> 1;
      b_reg  <= b_reg >> 1;
      count  <= count + 1'b1;
    end
  end

endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial (WIDTH=8): directed cases, back-to-back,
// input isolation during an operation, mid-operation reset and a random sweep.
module tb_sub_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] a, b;
  logic [7:0] out;
  logic       borrow_out, busy, done;

  int vectors = 0;
  int miscompares = 0;

  sub_serial #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b),
    .out(out), .borrow_out(borrow_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_diff(input logic [7:0] x, input logic [7:0] y);
    int d;
    d = (int'(x) - int'(y) + 256) % 256;
    return d[7:0];
  endfunction

  function automatic logic ref_borrow(input logic [7:0] x, input logic [7:0] y);
    return int'(x) < int'(y);
  endfunction

  // One full operation; sample k is taken 1 time unit after edge Ek (E0 = start edge).
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input string tag);
    logic exp_busy, exp_done;
    @(negedge clk);
    a = av; b = bv; en = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k == 0) en = 1'b0;
      exp_busy = (k <= 8);
      exp_done = (k == 8);
      vectors++;
      if (busy !== exp_busy) begin
        miscompares++;
        $display("FAIL %s busy k=%0d got %b want %b", tag, k, busy, exp_busy);
      end
      vectors++;
      if (done !== exp_done) begin
        miscompares++;
        $display("FAIL %s done k=%0d got %b want %b", tag, k, done, exp_done);
      end
      if (k == 8) begin
        vectors++;
        if (out !== ref_diff(av, bv)) begin
          miscompares++;
          $display("FAIL %s out a=%h b=%h got %h want %h", tag, av, bv, out, ref_diff(av, bv));
        end
        vectors++;
        if (borrow_out !== ref_borrow(av, bv)) begin
          miscompares++;
          $display("FAIL %s borrow a=%h b=%h got %b want %b", tag, av, bv, borrow_out, ref_borrow(av, bv));
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({out, borrow_out, busy, done} !== 11'b0) begin
      miscompares++;
      $display("FAIL reset outputs got out=%h borrow=%b busy=%b done=%b want all 0", out, borrow_out, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    do_op(8'h5A, 8'h23, "dir_5a_23");
    do_op(8'h10, 8'h20, "dir_10_20");
    do_op(8'hFF, 8'h01, "dir_ff_01");
    do_op(8'h00, 8'h00, "dir_00_00");
    // Result must hold in IDLE until the next start.
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (out !== 8'h00 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_hold got out=%h busy=%b want 00/0", out, busy);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int last = -1;
    @(negedge clk);
    a = 8'h80; b = 8'h01; en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        pulses++;
        vectors++;
        if (out !== 8'h7F || borrow_out !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b result cyc=%0d got %h/%b want 7f/0", c, out, borrow_out);
        end
        if (last >= 0) begin
          vectors++;
          if (c - last != 10) begin
            miscompares++;
            $display("FAIL b2b spacing got %0d want 10", c - last);
          end
        end
        last = c;
      end
    end
    en = 1'b0;
    vectors++;
    if (pulses != 4) begin
      miscompares++;
      $display("FAIL b2b pulses got %0d want 4", pulses);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_ignore_inputs();
    int extra = 0;
    @(negedge clk);
    a = 8'h33; b = 8'h11; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0; a = 8'hFF; b = 8'hFF;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      en = (k >= 1 && k <= 5);
      if (k == 8) begin
        vectors++;
        if (done !== 1'b1 || out !== 8'h22 || borrow_out !== 1'b0) begin
          miscompares++;
          $display("FAIL ignore result got done=%b out=%h borrow=%b want 1/22/0", done, out, borrow_out);
        end
      end else if (done === 1'b1 || (k > 9 && busy === 1'b1)) begin
        extra++;
      end
    end
    vectors++;
    if (extra != 0) begin
      miscompares++;
      $display("FAIL ignore extra_activity got %0d want 0", extra);
    end
    en = 1'b0; a = '0; b = '0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a = 8'h5A; b = 8'h23; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst pre busy got %b want 1", busy);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({out, borrow_out, busy, done} !== 11'b0) begin
      miscompares++;
      $display("FAIL midrst outputs got out=%h borrow=%b busy=%b done=%b want all 0", out, borrow_out, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    do_op(8'h09, 8'h0A, "after_rst");
  endtask

  task automatic test_random();
    logic [7:0] ra, rb;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      do_op(ra, rb, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_ignore_inputs();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sub_serial.md
Name: sub_serial

Overview:
- Bit-serial subtractor; the inverse-operation companion to the team's bit-serial adder.
- Latches two WIDTH-bit operands on a start request and computes a − b LSB-first, one bit per clock.
- Assembles the difference in a shift register and flags a final borrow.
- Sits beside the serial adder in the datapath; uses the same en-start / state-machine style, plus explicit busy/done status.

Parameters:
- WIDTH, 8: operand and result width in bits (≥2).
- CW, $clog2(WIDTH): bit-counter width (derived; not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  start request, sampled only in IDLE.
- a  input  WIDTH  minuend, sampled on the start edge.
- b  input  WIDTH  subtrahend, sampled on the start edge.
- out  output  WIDTH  difference (a − b) mod 2^WIDTH, registered.
- borrow_out  output  1  final borrow; 1 iff a < b unsigned, registered.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  high for exactly one cycle, while state = DONE.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE; a_reg, b_reg, out, borrow, count all 0.
  - Outputs: out=0, borrow_out=0, busy=0, done=0.
- States: IDLE=0, SUB=1, DONE=2 (2-bit encoding).
- IDLE:
  - en=1 → a_reg←a, b_reg←b, out←0, borrow←0, count←0; next state SUB.
  - en=0 → stay in IDLE; all registers hold.
- SUB (every cycle):
  - diff = a_reg[0] ^ b_reg[0] ^ borrow.
  - out ← {diff, out[WIDTH-1:1]}, so the LSB enters first and ends at bit 0.
  - borrow ← (~a_reg[0] & b_reg[0]) | (~a_reg[0] & borrow) | (b_reg[0] & borrow).
  - a_reg ← a_reg >> 1; b_reg ← b_reg >> 1; count ← count + 1.
  - When count == WIDTH−1 → next state DONE (this cycle still shifts). Otherwise stay in SUB.
- DONE:
  - No register updates; out and borrow hold. Next state IDLE unconditionally.
- borrow_out is the borrow register directly.
  - It shows intermediate values during SUB.
  - It is valid when done=1 and holds until the next start or reset.
- out holds its final value after DONE until the next accepted start, which clears it.
- Timing (edge E0 = the edge sampling en=1 in IDLE):
  - SUB occupies edges E1..E_WIDTH; DONE is entered at E_WIDTH.
  - done=1 in the cycle following E_WIDTH; IDLE is re-entered at E_WIDTH+1.
- en held high continuously → back-to-back operations, period WIDTH+2 cycles.
- en, a, b changes during SUB/DONE are ignored; operands are captured only at the start edge.
- Arithmetic: all WIDTH-bit, unsigned, wrap-around. Count wraps naturally but never exceeds WIDTH−1.
- No X propagation: every register has a defined value from reset.

Test Plan:
- Reset, then en=1 for 1 cycle with a=0x5A, b=0x23 (WIDTH=8) → busy high 9 cycles; done pulse in cycle 9 after start edge; out=0x37, borrow_out=0.
- a=0x10, b=0x20 → out=0xF0, borrow_out=1; a=0xFF, b=0x01 → out=0xFE, borrow_out=0; a=b=0x00 → out=0x00, borrow_out=0.
- en held high, a=0x80, b=0x01 constant → results 0x7F/borrow 0 repeat with done pulses exactly 10 cycles apart; out never shows partial value when done=1.
- Start a=0x33, b=0x11, then change a=0xFF, b=0xFF and pulse en during SUB → result still 0x22, borrow 0; no extra done pulse.
- Assert rst when count=3 mid-SUB → same cycle out=0, borrow_out=0, busy=0, done=0; after release, a new start a=0x09, b=0x0A → out=0xFF, borrow_out=1.
- Randomized sweep, 1000 operand pairs vs. reference model ((a−b) mod 256, a<b) → all match; busy/done timing matches the timing rule above.
